intc: RTL and testbench
=======================

Name: intc

Overview:
- 8-source memory-mapped interrupt controller on the 65C02 CPU bus, directly upstream of the CPU's IRQ/NMI inputs.
- Synchronises external sources and latches them as edge or level events.
- Applies enable masks and per-source IRQ/NMI routing, then drives the CPU's IRQ and NMI pins.
- The CPU reads status and vector registers and acknowledges through an 8-byte register window.

Parameters:
- BASE, 16'hFE00: base address of the register window; must be 8-byte aligned.
- PRIO_HIGH_FIRST, 0: 0 means the lowest source index has highest priority; 1 means the highest index does.

Ports:
- clk, input, 1: CPU clock.
- RST, input, 1: asynchronous reset, active-high.
- src, input, 8: raw asynchronous interrupt sources.
- AD, input, 16: CPU address bus (combinational from the CPU).
- DI, input, 8: write data, from the CPU's DO.
- WE, input, 1: CPU write enable.
- RDY, input, 1: CPU ready; bus accesses are qualified by it.
- DO, output, 8: read data, valid the cycle after the address.
- sel_q, output, 1: high when DO must be muxed onto the CPU DI bus.
- IRQ, output, 1: to CPU IRQ.
- NMI, output, 1: to CPU NMI.

Behaviour:
- Reset: all internal registers cleared; DO=0, sel_q=0, IRQ=0, NMI=0.
- Synchroniser: two flops s1/s2, plus a delay flop s3 for edge detection.
- Edge set condition: s2 & ~s3 (rising edge).
- Latency, src rise to IRQ: src rising before edge 1 → pending set at edge 3 → IRQ/NMI high after edge 4. Pulses shorter than one clk are not guaranteed to be caught.
- pending[i], edge source (EDGE[i]=1):
  - Set by a detected rising edge or by a SWSET write.
  - Cleared by a write-1 to STATUS.
  - Set wins when set and clear occur in the same cycle.
- pending[i], level source (EDGE[i]=0): loaded from s2 every cycle. STATUS clear and SWSET have no effect.
- Outputs, registered each cycle:
  - IRQ = |(pending & ENABLE & ~NMISEL)
  - NMI = |(pending & ENABLE & NMISEL)
  - Disabled sources keep their pending bits but do not assert either output.
- Bus select: sel = (AD[15:3] == BASE[15:3]); offset = AD[2:0].
- Write: at a clk edge with sel & WE & RDY.
- Read: at a clk edge with sel & ~WE & RDY, DO is loaded with the register value and sel_q is set to 1. Otherwise sel_q is set to 0.
- RDY low: DO and sel_q hold; no writes occur. Synchroniser, pending, IRQ and NMI keep running.
- Register map:
  - 0 STATUS: read pending; write-1 clears edge bits.
  - 1 ENABLE: R/W, reset 0.
  - 2 EDGE: R/W, reset 0 (1 = rising edge, 0 = level).
  - 3 NMISEL: R/W, reset 0 (1 = route to NMI).
  - 4 ACTIVE: read-only, pending & ENABLE.
  - 5 VECTOR: read-only.
    - Value is {5'b0, index} of the highest-priority bit of pending & ENABLE & ~NMISEL.
    - Value is 8'h80 if no such bit is set.
    - Bit 7 is the "none" flag.
  - 6 SWSET: write-1 sets edge pending bits; reads 0.
  - 7: reserved; reads 0, writes ignored.
- Changing EDGE from level to edge does not clear pending. The bit then behaves as edge and keeps its current value until cleared.
- Changing an EDGE bit does not re-arm detection. s3 tracks s2 continuously, so no spurious edge results.
- Reset asserted mid-operation clears everything immediately, asynchronously, including an in-flight read (sel_q=0).

Optional Feature:
- Macro: INTC_VECTOR_ACK_EN.
- Defined: a VECTOR read that reports index n (not 8'h80) clears pending[n] in the same edge, if that source is edge type. It acts as a combined read-and-acknowledge. A simultaneous new edge on n still sets the bit (set wins). Level sources are unaffected.
- Undefined: VECTOR reads have no side effects.

Test Plan:
- Reset values: pulse RST with src=8'hFF. Read ENABLE, EDGE, NMISEL → DO=00 on the cycle after each address. IRQ=0 and NMI=0 throughout.
- Edge IRQ path: write EDGE=01, ENABLE=01, then raise src[0] → IRQ high after the 4th clk edge. Read STATUS → 01. Read VECTOR → 00. Write STATUS=01 → IRQ low 1 cycle later.
- NMI routing and priority: EDGE=FF, ENABLE=FF, NMISEL=04, src[2]=src[5]=1 → NMI=1, IRQ=1. VECTOR reads 05, because bit 2 is routed to NMI and excluded.
- Level and SWSET: EDGE=00, ENABLE=08. Hold src[3]=1 → IRQ=1. Write STATUS=08 → IRQ stays 1. Drop src[3] → IRQ=0 four edges later. Write SWSET=08 → STATUS stays 00.
- Set/clear collision and RDY stall:
  - Write STATUS=01 on the same edge a rising edge of src[0] is detected → STATUS reads 01.
  - With RDY=0 and a write to ENABLE presented → ENABLE unchanged, DO/sel_q held.
- INTC_VECTOR_ACK_EN: two edge sources 1 and 6 pending and enabled, with PRIO_HIGH_FIRST=0 → VECTOR read returns 01, the next VECTOR read returns 06, the third returns 80, and IRQ ends low.

Source files
------------

// File: rtl/intc.sv
// intc: 8-source interrupt controller on the 65C02 bus with a register window at BASE.
// Define INTC_VECTOR_ACK_EN to make a VECTOR read also acknowledge the reported edge source.
module intc #(
    parameter logic [15:0] BASE            = 16'hFE00,
    parameter bit          PRIO_HIGH_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [7:0]  src,
    input  logic [15:0] AD,
    input  logic [7:0]  DI,
    input  logic        WE,
    input  logic        RDY,
    output logic [7:0]  DO,
    output logic        sel_q,
    output logic        IRQ,
    output logic        NMI
);

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_ENABLE = 3'd1;
    localparam logic [2:0] OFF_EDGE   = 3'd2;
    localparam logic [2:0] OFF_NMISEL = 3'd3;
    localparam logic [2:0] OFF_ACTIVE = 3'd4;
    localparam logic [2:0] OFF_VECTOR = 3'd5;
    localparam logic [2:0] OFF_SWSET  = 3'd6;

    logic [7:0] s1, s2, s3;
    logic [7:0] pending, enable, edge_r, nmisel;

    logic       sel;
    logic [2:0] offset;
    logic       rd, wr;
    logic [7:0] rise, set_mask, clr_mask, ack_mask, pend_next;
    logic [7:0] vec_cand, vector, rd_data;
    logic       vec_hit;
    logic [2:0] vec_idx;

    // Bus handshake: RDY is the only qualifier. An access (read or write) takes
    // effect at a clk edge only while sel and RDY are both high; with RDY low the
    // bus side (DO, sel_q, register writes) freezes while interrupt logic runs on.
    assign sel    = (AD[15:3] == BASE[15:3]);
    assign offset = AD[2:0];
    assign rd     = sel & ~WE & RDY;
    assign wr     = sel & WE & RDY;

    assign rise     = s2 & ~s3;
    assign vec_cand = pending & enable & ~nmisel;

    always_comb begin
        vec_hit = 1'b0;
        vec_idx = 3'd0;
        if (PRIO_HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (vec_cand[i]) begin
                    vec_hit = 1'b1;
                    vec_idx = 3'(i);
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (vec_cand[i]) begin
                    vec_hit = 1'b1;
                    vec_idx = 3'(i);
                end
            end
        end
    end

    assign vector = vec_hit ? {5'b0, vec_idx} : 8'h80;

    always_comb begin
        ack_mask = 8'h00;
`ifdef INTC_VECTOR_ACK_EN
        if (rd && offset == OFF_VECTOR && vec_hit)
            ack_mask[vec_idx] = 1'b1;
`endif
    end

    // Set beats clear for edge bits; level bits simply follow the synchronised input.
    assign set_mask  = rise | ((wr && offset == OFF_SWSET) ? DI : 8'h00);
    assign clr_mask  = ((wr && offset == OFF_STATUS) ? DI : 8'h00) | ack_mask;
    assign pend_next = (edge_r & (set_mask | (pending & ~clr_mask))) | (~edge_r & s2);

    always_comb begin
        rd_data = 8'h00;
        case (offset)
            OFF_STATUS: rd_data = pending;
            OFF_ENABLE: rd_data = enable;
            OFF_EDGE:   rd_data = edge_r;
            OFF_NMISEL: rd_data = nmisel;
            OFF_ACTIVE: rd_data = pending & enable;
            OFF_VECTOR: rd_data = vector;
            default:    rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            s1      <= 8'h00;
            s2      <= 8'h00;
            s3      <= 8'h00;
            pending <= 8'h00;
            enable  <= 8'h00;
            edge_r  <= 8'h00;
            nmisel  <= 8'h00;
            IRQ     <= 1'b0;
            NMI     <= 1'b0;
            DO      <= 8'h00;
            sel_q   <= 1'b0;
        end else begin
            s1      <= src;
            s2      <= s1;
            s3      <= s2;
            pending <= pend_next;
            IRQ     <= |(pending & enable & ~nmisel);
            NMI     <= |(pending & enable & nmisel);

            if (rd) begin
                DO    <= rd_data;
                sel_q <= 1'b1;
            end else if (RDY) begin
                sel_q <= 1'b0;
            end

            if (wr) begin
                case (offset)
                    OFF_ENABLE: enable <= DI;
                    OFF_EDGE:   edge_r <= DI;
                    OFF_NMISEL: nmisel <= DI;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_intc.sv
// Testbench for intc: directed scenarios plus randomized bus/source traffic,
// checked every cycle against a behavioural model of the controller.
module tb_intc;

    localparam logic [15:0] BASE = 16'hFE00;

    logic        clk = 1'b0;
    logic        RST;
    logic [7:0]  src;
    logic [15:0] AD;
    logic [7:0]  DI;
    logic        WE;
    logic        RDY;
    logic [7:0]  DO;
    logic        sel_q;
    logic        IRQ;
    logic        NMI;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    intc #(.BASE(BASE), .PRIO_HIGH_FIRST(1'b0)) dut (
        .clk(clk), .RST(RST), .src(src), .AD(AD), .DI(DI), .WE(WE), .RDY(RDY),
        .DO(DO), .sel_q(sel_q), .IRQ(IRQ), .NMI(NMI)
    );

    // clock / reset
    always #5 clk = ~clk;

    // behavioural model
    logic [7:0] m_pend = 8'h00, m_en = 8'h00, m_edge = 8'h00, m_nsel = 8'h00;
    logic [7:0] m_do = 8'h00;
    logic       m_selq = 1'b0, m_irq = 1'b0, m_nmi = 1'b0;
    logic [7:0] hist [0:2] = '{8'h00, 8'h00, 8'h00};

    function automatic logic [7:0] vec_of(input logic [7:0] p, en, ns);
        logic [7:0] c;
        c = p & en & ~ns;
        for (int i = 0; i < 8; i++)
            if (c[i]) return 8'(i);
        return 8'h80;
    endfunction

    function automatic logic [7:0] read_model(input logic [2:0] off);
        case (off)
            3'd0: return m_pend;
            3'd1: return m_en;
            3'd2: return m_edge;
            3'd3: return m_nsel;
            3'd4: return m_pend & m_en;
            3'd5: return vec_of(m_pend, m_en, m_nsel);
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or posedge RST) begin
        logic       in_win, is_rd, is_wr;
        logic [2:0] off;
        logic [7:0] np, vec, ack, synced, rising;
        if (RST) begin
            m_pend <= 8'h00; m_en <= 8'h00; m_edge <= 8'h00; m_nsel <= 8'h00;
            m_do <= 8'h00; m_selq <= 1'b0; m_irq <= 1'b0; m_nmi <= 1'b0;
            hist[0] <= 8'h00; hist[1] <= 8'h00; hist[2] <= 8'h00;
        end else begin
            in_win = (AD >= BASE) && (AD <= BASE + 16'd7);
            off    = 3'(AD - BASE);
            is_rd  = in_win && !WE && RDY;
            is_wr  = in_win && WE && RDY;
            synced = hist[1];
            rising = hist[1] & ~hist[2];
            vec    = vec_of(m_pend, m_en, m_nsel);
            ack    = 8'h00;
`ifdef INTC_VECTOR_ACK_EN
            if (is_rd && off == 3'd5 && vec != 8'h80) ack[vec[2:0]] = 1'b1;
`endif
            for (int i = 0; i < 8; i++) begin
                if (m_edge[i]) begin
                    if (rising[i] || (is_wr && off == 3'd6 && DI[i]))
                        np[i] = 1'b1;
                    else if ((is_wr && off == 3'd0 && DI[i]) || ack[i])
                        np[i] = 1'b0;
                    else
                        np[i] = m_pend[i];
                end else begin
                    np[i] = synced[i];
                end
            end
            m_irq <= (m_pend & m_en & ~m_nsel) != 8'h00;
            m_nmi <= (m_pend & m_en & m_nsel) != 8'h00;
            if (is_rd) begin
                m_do   <= read_model(off);
                m_selq <= 1'b1;
            end else if (RDY) begin
                m_selq <= 1'b0;
            end
            if (is_wr && off == 3'd1) m_en   <= DI;
            if (is_wr && off == 3'd2) m_edge <= DI;
            if (is_wr && off == 3'd3) m_nsel <= DI;
            m_pend  <= np;
            hist[0] <= src;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
    end

    // scoreboard
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_irq",   8'(IRQ),   8'(m_irq));
            check("model_nmi",   8'(NMI),   8'(m_nmi));
            check("model_sel_q", 8'(sel_q), 8'(m_selq));
            check("model_do",    DO,        m_do);
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] off, input logic [7:0] d);
        AD = BASE + 16'(off); DI = d; WE = 1'b1; RDY = 1'b1;
        @(negedge clk); #1;
        WE = 1'b0; AD = 16'h0000;
    endtask

    task automatic bus_rd(input logic [2:0] off, output logic [7:0] d);
        AD = BASE + 16'(off); WE = 1'b0; RDY = 1'b1;
        @(negedge clk); #1;
        d = DO;
        AD = 16'h0000;
    endtask

    logic [7:0] rdv;

    initial begin
        RST = 1'b1; src = 8'hFF; AD = 16'h0000; DI = 8'h00; WE = 1'b0; RDY = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (3) begin
            #1;
            check("rst_irq", 8'(IRQ), 8'h00);
            check("rst_nmi", 8'(NMI), 8'h00);
            @(negedge clk);
        end
        RST = 1'b0;
        bus_rd(3'd1, rdv); check("rst_enable", rdv, 8'h00);
        bus_rd(3'd2, rdv); check("rst_edge",   rdv, 8'h00);
        bus_rd(3'd3, rdv); check("rst_nmisel", rdv, 8'h00);
        check("rst_irq_after", 8'(IRQ), 8'h00);
        src = 8'h00;
        idle(4);

        // edge IRQ path and its latency
        bus_wr(3'd2, 8'h01);
        bus_wr(3'd1, 8'h01);
        idle(3);
        src = 8'h01;
        idle(3); check("edge_irq_lat3", 8'(IRQ), 8'h00);
        idle(1); check("edge_irq_lat4", 8'(IRQ), 8'h01);
        bus_rd(3'd0, rdv); check("edge_status", rdv, 8'h01);
        bus_rd(3'd5, rdv); check("edge_vector", rdv, 8'h00);
        bus_wr(3'd0, 8'h01); check("edge_clr_irq_hold", 8'(IRQ), 8'h01);
        idle(1); check("edge_clr_irq_low", 8'(IRQ), 8'h00);

        // NMI routing and priority
        src = 8'h00; idle(4);
        bus_wr(3'd2, 8'hFF);
        bus_wr(3'd1, 8'hFF);
        bus_wr(3'd3, 8'h04);
        src = 8'h24; idle(5);
        check("nmi_out", 8'(NMI), 8'h01);
        check("nmi_irq", 8'(IRQ), 8'h01);
        bus_rd(3'd5, rdv); check("nmi_vector", rdv, 8'h05);

        // level source and SWSET
        bus_wr(3'd0, 8'hFF);
        src = 8'h00;
        bus_wr(3'd2, 8'h00);
        bus_wr(3'd1, 8'h08);
        bus_wr(3'd3, 8'h00);
        src = 8'h08; idle(5);
        check("lvl_irq", 8'(IRQ), 8'h01);
        bus_wr(3'd0, 8'h08); idle(2);
        check("lvl_clr_noeffect", 8'(IRQ), 8'h01);
        src = 8'h00;
        idle(3); check("lvl_drop3", 8'(IRQ), 8'h01);
        idle(1); check("lvl_drop4", 8'(IRQ), 8'h00);
        bus_wr(3'd6, 8'h08);
        bus_rd(3'd0, rdv); check("lvl_swset", rdv, 8'h00);

        // set/clear collision
        bus_wr(3'd2, 8'h01);
        bus_wr(3'd1, 8'h01);
        bus_wr(3'd0, 8'hFF);
        idle(4);
        src = 8'h01;
        idle(2);
        bus_wr(3'd0, 8'h01);
        bus_rd(3'd0, rdv); check("collide_status", rdv, 8'h01);
        bus_wr(3'd0, 8'h01);
        idle(2);

        // RDY stall
        bus_rd(3'd2, rdv); check("stall_pre_do", rdv, 8'h01);
        AD = BASE + 16'd1; DI = 8'hFF; WE = 1'b1; RDY = 1'b0;
        idle(2);
        check("stall_sel_q", 8'(sel_q), 8'h01);
        check("stall_do", DO, 8'h01);
        RDY = 1'b1; WE = 1'b0; AD = 16'h0000;
        bus_rd(3'd1, rdv); check("stall_enable", rdv, 8'h01);

        // VECTOR read with two pending edge sources
        bus_wr(3'd0, 8'hFF);
        src = 8'h00;
        bus_wr(3'd2, 8'hFF);
        bus_wr(3'd1, 8'hFF);
        bus_wr(3'd3, 8'h00);
        bus_wr(3'd6, 8'h42);
        idle(2);
        bus_rd(3'd5, rdv); check("vack_first", rdv, 8'h01);
`ifdef INTC_VECTOR_ACK_EN
        bus_rd(3'd5, rdv); check("vack_second", rdv, 8'h06);
        bus_rd(3'd5, rdv); check("vack_third", rdv, 8'h80);
        idle(2); check("vack_irq_low", 8'(IRQ), 8'h00);
`else
        bus_rd(3'd5, rdv); check("vec_noack_second", rdv, 8'h01);
        idle(2); check("vec_noack_irq", 8'(IRQ), 8'h01);
`endif

        // randomized traffic, with one asynchronous reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                AD = BASE + 16'd4; WE = 1'b0; RDY = 1'b1;
                @(posedge clk); #2;
                RST = 1'b1;
                @(negedge clk); #1;
                check("midrst_sel_q", 8'(sel_q), 8'h00);
                check("midrst_irq", 8'(IRQ), 8'h00);
                RST = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) src = 8'($urandom);
            AD  = ($urandom_range(0, 3) != 0) ? BASE + 16'($urandom_range(0, 7))
                                              : 16'($urandom);
            WE  = 1'($urandom_range(0, 1));
            RDY = ($urandom_range(0, 3) != 0);
            DI  = 8'($urandom);
            @(negedge clk); #1;
        end
        WE = 1'b0; RDY = 1'b1; AD = 16'h0000;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
